// File: rtl/uart_tx_os.sv
// UART transmitter running on the oversampled receive clock (Prescale ticks per bit).
// A parallel word is accepted on a one-cycle Data_Valid strobe. It is sent as one frame:
// a start bit, DATA_WIDTH data bits LSB first, an optional parity bit and one stop bit.
// A strobe that arrives in the last stop cycle starts the next frame with no idle gap.
//
// Ports:
//   clk_RX     oversampled clock, rising edge
//   rst        asynchronous active-low reset
//   P_DATA     parallel word to send
//   Data_Valid one-cycle strobe qualifying P_DATA and the config inputs
//   PAR_EN     1 = append a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   Prescale   clk_RX cycles per bit; values below 4 are treated as 4
//   TX_OUT     registered serial line, idles high
//   busy       registered, high from frame start to the end of the stop bit
module uart_tx_os #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   clk_RX,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   Data_Valid,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] Prescale,
    output logic                   TX_OUT,
    output logic                   busy
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);
    localparam logic [PRESC_WIDTH-1:0] MinPresc = PRESC_WIDTH'(4);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state;
    logic [DATA_WIDTH-1:0]  data_sh;
    logic [CntW-1:0]        bit_cnt;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [PRESC_WIDTH-1:0] presc_lat;
    logic                   par_en_lat;
    logic                   par_bit;
    logic                   tx_q;
    logic                   busy_q;

    logic                   boundary;
    logic                   accept;
    logic [PRESC_WIDTH-1:0] presc_clamped;

    always_comb begin
        boundary      = (presc_cnt == presc_lat - 1'b1);
        // Idle, or the final cycle of the stop bit for back-to-back frames.
        accept        = Data_Valid &&
                        ((state == StIdle) || ((state == StStop) && boundary));
        presc_clamped = (Prescale < MinPresc) ? MinPresc : Prescale;
    end

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            data_sh    <= '0;
            bit_cnt    <= '0;
            presc_cnt  <= '0;
            presc_lat  <= '0;
            par_en_lat <= 1'b0;
            par_bit    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else if (accept) begin
            state      <= StStart;
            data_sh    <= P_DATA;
            bit_cnt    <= '0;
            presc_cnt  <= '0;
            presc_lat  <= presc_clamped;
            par_en_lat <= PAR_EN;
            // Computed once from the word being latched, so it always matches the frame.
            par_bit    <= (^P_DATA) ^ PAR_TYP;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                StStart: begin
                    if (boundary) begin
                        presc_cnt <= '0;
                        state     <= StData;
                        tx_q      <= data_sh[0];
                    end else begin
                        presc_cnt <= presc_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (boundary) begin
                        presc_cnt <= '0;
                        if (bit_cnt == LastBit) begin
                            if (par_en_lat) begin
                                state <= StParity;
                                tx_q  <= par_bit;
                            end else begin
                                state <= StStop;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // The next bit sits at index 1 before this shift.
                            tx_q    <= data_sh[1];
                            data_sh <= data_sh >> 1;
                        end
                    end else begin
                        presc_cnt <= presc_cnt + 1'b1;
                    end
                end
                StParity: begin
                    if (boundary) begin
                        presc_cnt <= '0;
                        state     <= StStop;
                        tx_q      <= 1'b1;
                    end else begin
                        presc_cnt <= presc_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (boundary) begin
                        presc_cnt <= '0;
                        state     <= StIdle;
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        presc_cnt <= presc_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    presc_cnt <= '0;
                    bit_cnt   <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_os.sv
// Randomised scoreboard bench for uart_tx_os. The driver decides from frame lengths
// whether each strobe is accepted and queues the expected frame with its start edge.
// The monitor checks TX_OUT and busy on every falling edge against that queue.
module tb_uart_tx_os;

    logic       clk_RX = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    uart_tx_os #(
        .DATA_WIDTH  (8),
        .PRESC_WIDTH (6)
    ) dut (
        .clk_RX     (clk_RX),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk_RX = ~clk_RX;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_typ;
        int         p;
        int         len;
        int         start;
    } frame_t;

    frame_t sb[$];
    int ecount      = 0;   // rising edges seen so far
    int busy_until  = 0;   // first edge at which a new strobe is accepted
    int n_checks    = 0;
    int n_fail      = 0;

    always @(posedge clk_RX) ecount <= ecount + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, ecount, act, exp);
        end
    endtask

    // Expected line level for bit slot idx of a frame.
    function automatic int exp_bit(input frame_t f, input int idx);
        logic [7:0] d;
        int         ones;
        d    = f.data;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (idx == 0) return 0;
        if (idx <= 8) return int'(d[idx-1]);
        if (idx == 9 && f.par_en) begin
            // Even: line bit makes total ones even; odd: makes it odd.
            if (f.par_typ) return ((ones % 2) == 0) ? 1 : 0;
            return ones % 2;
        end
        return 1;
    endfunction

    task automatic step();
        @(posedge clk_RX);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int p);
        frame_t f;
        int     s;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = 6'(p);
        Data_Valid = 1'b1;
        s          = ecount + 1;
        if (s >= busy_until) begin
            f.data    = d;
            f.par_en  = pe;
            f.par_typ = pt;
            f.p       = (p < 4) ? 4 : p;
            f.len     = (pe ? 11 : 10) * f.p;
            f.start   = s;
            busy_until = s + f.len;
            sb.push_back(f);
        end
        step();
        Data_Valid = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        while (ecount < e) step();
    endtask

    task automatic wait_idle();
        while (ecount < busy_until + 1) step();
    endtask

    // Monitor
    initial begin : monitor
        frame_t cur;
        bit     active;
        int     k;
        active = 1'b0;
        forever begin
            @(negedge clk_RX);
            if (!rst) begin
                active = 1'b0;
                check("reset_tx", int'(TX_OUT), 1);
                check("reset_busy", int'(busy), 0);
            end else begin
                if (!active && sb.size() > 0 && sb[0].start == ecount) begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                end
                if (active) begin
                    k = ecount - cur.start;
                    check($sformatf("frame_%02h_slot%0d_tx", cur.data, k / cur.p),
                          int'(TX_OUT), exp_bit(cur, k / cur.p));
                    check($sformatf("frame_%02h_busy", cur.data), int'(busy), 1);
                    if (k == cur.len - 1) active = 1'b0;
                end else begin
                    check("idle_tx", int'(TX_OUT), 1);
                    check("idle_busy", int'(busy), 0);
                end
            end
        end
    end

    initial begin : timeout
        #600000;
        $display("FAIL timeout: stimulus did not complete, got edge %0d, expected end", ecount);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int fs;
        rst        = 1'b0;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        repeat (3) step();
        rst = 1'b1;
        step();

        send(8'hA5, 1'b0, 1'b0, 8);
        wait_idle();
        send(8'h07, 1'b1, 1'b0, 16);
        wait_idle();
        send(8'h07, 1'b1, 1'b1, 16);
        wait_idle();

        // Back-to-back: second strobe lands on the last stop cycle.
        send(8'h55, 1'b0, 1'b0, 8);
        wait_edge(busy_until - 1);
        send(8'h3C, 1'b0, 1'b0, 8);
        wait_idle();

        // Mid-frame strobe and config churn must not disturb the frame.
        send(8'h96, 1'b1, 1'b1, 10);
        repeat (25) step();
        send(8'hFF, 1'b0, 1'b0, 5);
        P_DATA   = 8'h00;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd4;
        repeat (30) step();
        wait_idle();

        // Prescale clamp.
        send(8'h01, 1'b0, 1'b0, 2);
        wait_idle();

        // Asynchronous reset in the middle of data bit 3.
        send(8'h5A, 1'b0, 1'b0, 8);
        fs = busy_until - 80;
        wait_edge(fs + 4 * 8 + 2);
        #1 rst = 1'b0;
        #1;
        check("async_reset_tx", int'(TX_OUT), 1);
        check("async_reset_busy", int'(busy), 0);
        sb.delete();
        busy_until = 0;
        repeat (3) step();
        rst = 1'b1;
        step();
        send(8'h81, 1'b0, 1'b0, 8);
        wait_idle();

        // Random traffic with back-to-back, mid-frame and idle-gap strobes.
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0: wait_edge(busy_until - 1);
                1: repeat ($urandom_range(0, 5)) step();
                2: begin
                    wait_idle();
                    repeat ($urandom_range(0, 3)) step();
                end
                default: repeat ($urandom_range(0, 100)) step();
            endcase
            send(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 20)));
        end
        wait_idle();
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_os.md
Name: uart_tx_os

Overview:
UART transmitter for the UART block, the counterpart of the UART receiver. It runs on the same oversampled clock, clk_RX, at Prescale × baud. The block accepts a parallel byte with a one-cycle valid strobe and serialises it as one frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit. It feeds the serial line that the receiver samples, which allows loopback at the system level.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESC_WIDTH, 6, width of the Prescale input

Ports:
clk_RX  input  1  oversampled clock (Prescale ticks per bit); all logic is on the rising edge
rst  input  1  reset, asynchronous, active-low
P_DATA  input  DATA_WIDTH  parallel byte to send
Data_Valid  input  1  one-cycle strobe; P_DATA is valid
PAR_EN  input  1  1 = append a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESC_WIDTH  clk_RX cycles per bit; supported range 4..63
TX_OUT  output  1  serial line, registered; idles high
busy  output  1  registered; high from frame start to the end of the stop bit

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; TX_OUT = 1; busy = 0.
  - Shift register, bit counter, prescale counter and all latched configuration are cleared.
  - Reset mid-frame aborts the frame immediately and returns TX_OUT to 1.
- Accept:
  - Accept happens when Data_Valid = 1 and the FSM is in IDLE, or in the last cycle of STOP.
  - At accept, latch P_DATA, PAR_EN, PAR_TYP and Prescale.
  - Prescale values below 4 are latched as 4.
  - Data_Valid in any other cycle is ignored, and the frame in flight is unaffected.
  - Config inputs changing mid-frame have no effect.
- Parity is computed from the latched data, not the live P_DATA:
  - even: parity = XOR of the data bits
  - odd: parity = NOT(XOR of the data bits)
- Latency: Data_Valid accepted at cycle N → TX_OUT = 0 and busy = 1 from cycle N+1.
- Bit timing:
  - Each bit is held for exactly Prescale(latched) cycles.
  - A prescale counter runs 0..P-1; the bit boundary is at P-1.
- FSM states and transitions:
  - IDLE: TX_OUT = 1, busy = 0. → START on accept.
  - START: TX_OUT = 0. → DATA at the bit boundary.
  - DATA: TX_OUT = data[bit_cnt], bit_cnt 0..7, LSB first. Leaves at the boundary of bit 7: → PARITY if PAR_EN latched, else → STOP.
  - PARITY: TX_OUT = parity bit. → STOP at the bit boundary.
  - STOP: TX_OUT = 1. At the bit boundary: → START if accept happens in that cycle (back-to-back, no idle gap), else → IDLE.
  - Illegal state encodings → IDLE.
- Frame length: 10·P cycles, or 11·P with parity. Back-to-back frames run with zero idle cycles between them.
- busy:
  - Stays 1 through back-to-back frames.
  - Falls to 0 the cycle after the last stop cycle when no new accept happened in that cycle.
- Glitch-free output: TX_OUT is driven directly from a flop, with no combinational path to the pin.

Test Plan:
- Reset, then Prescale = 8, PAR_EN = 0, P_DATA = 0xA5, Data_Valid one cycle → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; busy high for exactly 80 cycles.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, P_DATA = 0x07 → parity bit 1; frame 176 cycles. Repeat with PAR_TYP = 1 → parity bit 0.
- Back-to-back: send 0x55 with Data_Valid pulsed in the last STOP cycle together with 0x3C → second start bit begins the very next cycle; busy never drops.
- Data_Valid pulsed mid-frame with 0xFF, and P_DATA/PAR_EN/Prescale changed mid-frame → current frame bits unchanged; 0xFF is never transmitted.
- Prescale = 2, P_DATA = 0x01 → each bit held 4 cycles (clamp); frame 40 cycles.
- rst asserted during DATA bit 3 → TX_OUT = 1 and busy = 0 immediately (asynchronous); after release, a new frame 0x81 transmits correctly from the start bit.
